// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state type and SPI mode decoding for the single-CS SPI master
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRANSFER,
    CS_INACTIVE
  } cs_state_e;

  function automatic logic mode_cpol(input int mode);
    return (mode == 2) || (mode == 3);
  endfunction

  function automatic logic mode_cpha(input int mode);
    return (mode == 1) || (mode == 3);
  endfunction

endpackage

// File: rtl/spi_master_single_cs_if.sv
// rtl/spi_master_single_cs_if.sv - per-byte TX/RX handshake between the card controller and the SPI master
interface spi_master_single_cs_if #(
  parameter int MAX_BYTES_PER_CS = 2
);
  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);

  logic [CW-1:0] i_TX_Count;
  logic [7:0]    i_TX_Byte;
  logic          i_TX_DV;
  logic          o_TX_Ready;
  logic [CW-1:0] o_RX_Count;
  logic          o_RX_DV;
  logic [7:0]    o_RX_Byte;

  modport master (
    output i_TX_Count, i_TX_Byte, i_TX_DV,
    input  o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Byte
  );

  modport slave (
    input  i_TX_Count, i_TX_Byte, i_TX_DV,
    output o_TX_Ready, o_RX_Count, o_RX_DV, o_RX_Byte
  );

endinterface

// File: rtl/spi_master_byte.sv
// rtl/spi_master_byte.sv - one full-duplex SPI byte: 16 clock edges plus MSB-first TX/RX shift registers
module spi_master_byte #(
  parameter bit CPOL              = 1'b0,
  parameter bit CPHA              = 1'b0,
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_SPI_Clk,
  input  logic       i_SPI_MISO,
  output logic       o_SPI_MOSI
);

  localparam int HW = $clog2(CLKS_PER_HALF_BIT);

  logic [HW-1:0] half_cnt;
  logic [4:0]    edges_left;
  logic          busy;
  logic          last_edge;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic          start;
  logic          spi_edge;
  logic          lead_edge;
  logic          trail_edge;
  logic          sample_edge;
  logic          shift_out_edge;

  assign start    = i_TX_DV & o_TX_Ready;
  assign spi_edge = busy && (half_cnt == HW'(CLKS_PER_HALF_BIT - 1));
  // edges_left counts down from 16, so an even count marks a leading edge
  assign lead_edge      = spi_edge & ~edges_left[0];
  assign trail_edge     = spi_edge & edges_left[0];
  assign sample_edge    = CPHA ? trail_edge : lead_edge;
  assign shift_out_edge = CPHA ? lead_edge : trail_edge;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      half_cnt   <= '0;
      edges_left <= '0;
      busy       <= 1'b0;
      last_edge  <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      o_TX_Ready <= 1'b0;
      o_RX_DV    <= 1'b0;
      o_RX_Byte  <= '0;
      o_SPI_Clk  <= CPOL;
      o_SPI_MOSI <= 1'b0;
    end else begin
      last_edge <= spi_edge && (edges_left == 5'd1);
      o_RX_DV   <= last_edge;
      if (last_edge) begin
        o_RX_Byte <= rx_sr;
      end
      if (start) begin
        o_TX_Ready <= 1'b0;
        busy       <= 1'b1;
        edges_left <= 5'd16;
        half_cnt   <= '0;
        if (!CPHA) begin
          o_SPI_MOSI <= i_TX_Byte[7];
          tx_sr      <= {i_TX_Byte[6:0], 1'b0};
        end else begin
          tx_sr      <= i_TX_Byte;
        end
      end else if (busy) begin
        if (spi_edge) begin
          half_cnt   <= '0;
          edges_left <= edges_left - 5'd1;
          o_SPI_Clk  <= ~o_SPI_Clk;
          if (edges_left == 5'd1) begin
            busy <= 1'b0;
          end
        end else begin
          half_cnt <= half_cnt + 1'b1;
        end
        if (shift_out_edge) begin
          o_SPI_MOSI <= tx_sr[7];
          tx_sr      <= {tx_sr[6:0], 1'b0};
        end
        if (sample_edge) begin
          rx_sr <= {rx_sr[6:0], i_SPI_MISO};
        end
      end else begin
        o_TX_Ready <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_single_cs.sv
// rtl/spi_master_single_cs.sv - SPI master holding one chip select low across a multi-byte burst
module spi_master_single_cs
  import spi_pkg::*;
#(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int MAX_BYTES_PER_CS  = 2,
  parameter int CS_INACTIVE_CLKS  = 1
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst_L,
  spi_master_single_cs_if.slave        bus,
  output logic                         o_SPI_Clk,
  input  logic                         i_SPI_MISO,
  output logic                         o_SPI_MOSI,
  output logic                         o_SPI_CS_n
);

  localparam int CW   = $clog2(MAX_BYTES_PER_CS + 1);
  localparam int IW   = (CS_INACTIVE_CLKS > 0) ? $clog2(CS_INACTIVE_CLKS + 1) : 1;
  localparam bit CPOL = mode_cpol(SPI_MODE);
  localparam bit CPHA = mode_cpha(SPI_MODE);

  cs_state_e     state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [IW-1:0] inact_q, inact_d;
  logic          cs_n_q, cs_n_d;
  logic [CW-1:0] rx_cnt_q;
  logic          eng_ready;
  logic          can_accept;
  logic          accept;
  logic          rx_dv;
  logic [7:0]    rx_byte;

  assign can_accept     = eng_ready & ((state_q == IDLE) | ((state_q == TRANSFER) & (rem_q != '0)));
  assign accept         = bus.i_TX_DV & can_accept;
  assign bus.o_TX_Ready = ~bus.i_TX_DV & can_accept;
  assign o_SPI_CS_n     = cs_n_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
      rem_q   <= '0;
      inact_q <= '0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      inact_q <= inact_d;
      cs_n_q  <= cs_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    inact_d = inact_q;
    cs_n_d  = cs_n_q;
    case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        if (accept) begin
          // a zero count still sends the byte being strobed
          rem_d   = (bus.i_TX_Count == '0) ? '0 : bus.i_TX_Count - 1'b1;
          cs_n_d  = 1'b0;
          state_d = TRANSFER;
        end
      end
      TRANSFER: begin
        if (accept) begin
          rem_d = rem_q - 1'b1;
        end else if (eng_ready && (rem_q == '0)) begin
          cs_n_d  = 1'b1;
          inact_d = IW'(CS_INACTIVE_CLKS);
          state_d = CS_INACTIVE;
        end
      end
      CS_INACTIVE: begin
        if (inact_q == '0) begin
          state_d = IDLE;
        end else begin
          inact_d = inact_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // the registered count lags o_RX_DV by a cycle, so fold the pulse in to read k on byte k
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_cnt_q <= '0;
    end else if (cs_n_q) begin
      rx_cnt_q <= '0;
    end else if (rx_dv) begin
      rx_cnt_q <= rx_cnt_q + 1'b1;
    end
  end

  assign bus.o_RX_Count = rx_cnt_q + CW'(rx_dv);
  assign bus.o_RX_DV    = rx_dv;
  assign bus.o_RX_Byte  = rx_byte;

  spi_master_byte #(
    .CPOL              (CPOL),
    .CPHA              (CPHA),
    .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
  ) u_byte (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_TX_DV    (accept),
    .i_TX_Byte  (bus.i_TX_Byte),
    .o_TX_Ready (eng_ready),
    .o_RX_DV    (rx_dv),
    .o_RX_Byte  (rx_byte),
    .o_SPI_Clk  (o_SPI_Clk),
    .i_SPI_MISO (i_SPI_MISO),
    .o_SPI_MOSI (o_SPI_MOSI)
  );

endmodule

// File: tb/tb_spi_master_single_cs.sv
// tb/tb_spi_master_single_cs.sv - scoreboard bench for spi_master_single_cs in modes 0, 3 and 1
module tb_spi_master_single_cs;

  localparam int H     = 5;
  localparam int MAXB  = 2;
  localparam int INACT = 10;
  localparam int CW    = $clog2(MAXB + 1);
  localparam int NDUT  = 3;

  typedef struct packed {
    logic [1:0]    dut;
    logic [CW-1:0] cnt;
    logic [7:0]    data;
  } exp_t;

  logic r_Clk   = 1'b0;
  logic r_Rst_L = 1'b0;
  always #5 r_Clk = ~r_Clk;

  logic [CW-1:0]   tx_count [NDUT];
  logic [7:0]      tx_byte  [NDUT];
  logic [CW-1:0]   rx_count [NDUT];
  logic [7:0]      rx_byte  [NDUT];
  logic [NDUT-1:0] tx_dv;
  logic [NDUT-1:0] tx_ready;
  logic [NDUT-1:0] rx_dv;
  logic [NDUT-1:0] spi_clk;
  logic [NDUT-1:0] spi_mosi;
  logic [NDUT-1:0] spi_cs_n;
  logic [NDUT-1:0] miso_high;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic burst_mon = 1'b0;
  logic cs_glitch = 1'b0;

  // dut0: mode 0, dut1: mode 3, dut2: mode 1; idle clock levels are therefore 0,1,0
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int MODE = (g == 0) ? 0 : ((g == 1) ? 3 : 1);
    logic miso;
    spi_master_single_cs_if #(.MAX_BYTES_PER_CS(MAXB)) sif ();
    assign sif.i_TX_Count = tx_count[g];
    assign sif.i_TX_Byte  = tx_byte[g];
    assign sif.i_TX_DV    = tx_dv[g];
    assign tx_ready[g]    = sif.o_TX_Ready;
    assign rx_count[g]    = sif.o_RX_Count;
    assign rx_dv[g]       = sif.o_RX_DV;
    assign rx_byte[g]     = sif.o_RX_Byte;
    assign miso           = miso_high[g] ? 1'b1 : spi_mosi[g];
    spi_master_single_cs #(
      .SPI_MODE          (MODE),
      .CLKS_PER_HALF_BIT (H),
      .MAX_BYTES_PER_CS  (MAXB),
      .CS_INACTIVE_CLKS  (INACT)
    ) dut (
      .i_Clk      (r_Clk),
      .i_Rst_L    (r_Rst_L),
      .bus        (sif.slave),
      .o_SPI_Clk  (spi_clk[g]),
      .i_SPI_MISO (miso),
      .o_SPI_MOSI (spi_mosi[g]),
      .o_SPI_CS_n (spi_cs_n[g])
    );
  end

  always @(negedge r_Clk) begin
    if (burst_mon && spi_cs_n[0]) cs_glitch <= 1'b1;
  end

  task automatic send(input int g, input logic [7:0] b, input logic [CW-1:0] cnt,
                      input logic [CW-1:0] exp_cnt);
    int   n;
    exp_t e;
    n = 0;
    while (!tx_ready[g] && n < 300) begin
      @(negedge r_Clk);
      n++;
    end
    total++;
    if (!tx_ready[g]) begin
      bad++;
      $display("FAIL send_ready dut%0d: tx_ready=%b required 1", g, tx_ready[g]);
    end
    tx_byte[g]  = b;
    tx_count[g] = cnt;
    tx_dv[g]    = 1'b1;
    e.dut  = 2'(g);
    e.cnt  = exp_cnt;
    e.data = miso_high[g] ? 8'hFF : b;
    exp_q.push_back(e);
    @(negedge r_Clk);
    tx_dv[g] = 1'b0;
  endtask

  task automatic wait_rx(input int g, output int cyc, output int rises, output logic mosi_hi);
    logic prev;
    exp_t e;
    cyc     = 0;
    rises   = 0;
    mosi_hi = 1'b0;
    prev    = spi_clk[g];
    while (!rx_dv[g] && cyc < 400) begin
      @(negedge r_Clk);
      cyc++;
      if (spi_clk[g] && !prev) rises++;
      prev = spi_clk[g];
      if (spi_mosi[g]) mosi_hi = 1'b1;
    end
    total++;
    if (!rx_dv[g]) begin
      bad++;
      $display("FAIL rx_timeout dut%0d: no rx_dv after %0d cycles", g, cyc);
    end else if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL rx_unexpected dut%0d: rx_byte=%h with empty scoreboard", g, rx_byte[g]);
    end else begin
      e = exp_q.pop_front();
      total += 2;
      if (rx_byte[g] !== e.data || e.dut != 2'(g)) begin
        bad++;
        $display("FAIL rx_byte dut%0d: got %h required %h", g, rx_byte[g], e.data);
      end
      if (rx_count[g] !== e.cnt) begin
        bad++;
        $display("FAIL rx_count dut%0d: got %0d required %0d", g, rx_count[g], e.cnt);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if (spi_cs_n !== 3'b111 || spi_clk !== 3'b010 || tx_ready !== 3'b000 ||
        rx_dv !== 3'b000 || spi_mosi !== 3'b000 || rx_count[0] !== '0 || rx_byte[0] !== 8'h00) begin
      bad++;
      $display("FAIL %s: cs_n=%b clk=%b rdy=%b rxdv=%b mosi=%b cnt=%0d byte=%h required 111 010 000 000 000 0 00",
               tag, spi_cs_n, spi_clk, tx_ready, rx_dv, spi_mosi, rx_count[0], rx_byte[0]);
    end
  endtask

  task automatic release_reset(input string tag);
    int n;
    @(negedge r_Clk);
    r_Rst_L = 1'b1;
    n = 0;
    while (!tx_ready[0] && n < 5) begin
      @(negedge r_Clk);
      n++;
    end
    total++;
    if (!tx_ready[0] || n > 2) begin
      bad++;
      $display("FAIL %s: tx_ready=%b after %0d cycles, required 1 within 2", tag, tx_ready[0], n);
    end
  endtask

  task automatic test_reset();
    for (int g = 0; g < NDUT; g++) begin
      tx_dv[g]     = 1'b0;
      tx_byte[g]   = 8'h00;
      tx_count[g]  = '0;
      miso_high[g] = 1'b0;
    end
    r_Rst_L = 1'b0;
    repeat (3) @(negedge r_Clk);
    check_reset_values("reset_values");
    release_reset("reset_ready");
  endtask

  task automatic test_single();
    int   cyc, rises, hi, n;
    logic mh;
    total++;
    if (spi_cs_n[0] !== 1'b1) begin
      bad++;
      $display("FAIL single_cs_idle: cs_n=%b required 1", spi_cs_n[0]);
    end
    send(0, 8'h10, CW'(1), CW'(1));
    total++;
    if (spi_cs_n[0] !== 1'b0) begin
      bad++;
      $display("FAIL single_cs_low: cs_n=%b required 0", spi_cs_n[0]);
    end
    wait_rx(0, cyc, rises, mh);
    total += 2;
    if (rises != 8) begin
      bad++;
      $display("FAIL single_rises: got %0d required 8", rises);
    end
    if (cyc != 16 * H + 1) begin
      bad++;
      $display("FAIL single_latency: got %0d required %0d", cyc, 16 * H + 1);
    end
    hi = 0;
    n  = 0;
    while (!tx_ready[0] && n < 100) begin
      @(negedge r_Clk);
      n++;
      if (spi_cs_n[0]) hi++;
    end
    total++;
    if (!tx_ready[0] || hi < INACT || spi_cs_n[0] !== 1'b1) begin
      bad++;
      $display("FAIL single_cs_inactive: cs high %0d cycles ready=%b, required >=%0d and ready", hi, tx_ready[0], INACT);
    end
  endtask

  task automatic test_back_to_back();
    int   cyc, rises;
    logic mh;
    cs_glitch = 1'b0;
    send(0, 8'h11, CW'(2), CW'(1));
    burst_mon = 1'b1;
    wait_rx(0, cyc, rises, mh);
    send(0, 8'h12, CW'(2), CW'(2));
    wait_rx(0, cyc, rises, mh);
    burst_mon = 1'b0;
    total++;
    if (cs_glitch !== 1'b0) begin
      bad++;
      $display("FAIL burst_cs_held: cs rose inside burst (glitch=%b) required 0", cs_glitch);
    end
    repeat (3) @(negedge r_Clk);
    total++;
    if (spi_cs_n[0] !== 1'b1) begin
      bad++;
      $display("FAIL burst_cs_end: cs_n=%b required 1", spi_cs_n[0]);
    end
  endtask

  task automatic test_modes();
    int   cyc, rises;
    logic mh;
    total++;
    if (spi_clk[1] !== 1'b1) begin
      bad++;
      $display("FAIL mode3_idle_clk: got %b required 1", spi_clk[1]);
    end
    send(1, 8'hA5, CW'(1), CW'(1));
    wait_rx(1, cyc, rises, mh);
    total++;
    if (rises != 8) begin
      bad++;
      $display("FAIL mode3_rises: got %0d required 8", rises);
    end
    send(2, 8'h3C, CW'(0), CW'(1));
    wait_rx(2, cyc, rises, mh);
    repeat (3) @(negedge r_Clk);
    total++;
    if (spi_cs_n[2] !== 1'b1 || spi_clk[2] !== 1'b0) begin
      bad++;
      $display("FAIL count0_single: cs_n=%b clk=%b required 1 0", spi_cs_n[2], spi_clk[2]);
    end
  endtask

  task automatic test_miso_high();
    int   cyc, rises;
    logic mh;
    miso_high[0] = 1'b1;
    send(0, 8'h00, CW'(1), CW'(1));
    wait_rx(0, cyc, rises, mh);
    total++;
    if (mh !== 1'b0) begin
      bad++;
      $display("FAIL miso_high_mosi: mosi went %b required 0", mh);
    end
    miso_high[0] = 1'b0;
  endtask

  task automatic test_inactive_ignore();
    int   cyc, rises, n, dv_seen, cs_low;
    logic mh;
    send(0, 8'h5A, CW'(1), CW'(1));
    wait_rx(0, cyc, rises, mh);
    n = 0;
    while (!spi_cs_n[0] && n < 5) begin
      @(negedge r_Clk);
      n++;
    end
    total++;
    if (tx_ready[0] !== 1'b0 || spi_cs_n[0] !== 1'b1) begin
      bad++;
      $display("FAIL inactive_state: ready=%b cs_n=%b required 0 1", tx_ready[0], spi_cs_n[0]);
    end
    tx_byte[0]  = 8'h77;
    tx_count[0] = CW'(1);
    tx_dv[0]    = 1'b1;
    @(negedge r_Clk);
    tx_dv[0] = 1'b0;
    dv_seen = 0;
    cs_low  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge r_Clk);
      if (rx_dv[0]) dv_seen++;
      if (!spi_cs_n[0]) cs_low++;
    end
    total++;
    if (dv_seen != 0 || cs_low != 0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL inactive_ignore: rx_dv=%0d cs_low=%0d pending=%0d required 0 0 0", dv_seen, cs_low, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    send(0, 8'hC3, CW'(2), CW'(1));
    repeat (20) @(negedge r_Clk);
    total++;
    if (spi_cs_n[0] !== 1'b0) begin
      bad++;
      $display("FAIL mid_active: cs_n=%b required 0", spi_cs_n[0]);
    end
    #2;
    r_Rst_L = 1'b0;
    #1;
    check_reset_values("mid_reset_values");
    exp_q.delete();
    release_reset("mid_reset_ready");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_modes();
    test_miso_high();
    test_inactive_ignore();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
